// File: rtl/scoreboard_regfile_if.sv
// rtl/scoreboard_regfile_if.sv - register file / scoreboard bus interface
//
// Purpose: bundles the read, write, busy-set and status signals of
//          scoreboard_regfile so they travel as one port.
// Signals:
//   a1, a2          source read addresses          (master -> slave)
//   r1, r2          source read data               (slave  -> master)
//   a3, di3, we3    write port A, ALU writeback    (master -> slave)
//   a4, di4, we4    write port B, load writeback   (master -> slave)
//   bs_addr, bs_en  busy set on load issue         (master -> slave)
//   busy1, busy2    source pending flags           (slave  -> master)
//   stall           busy1 | busy2                  (slave  -> master)
interface scoreboard_regfile_if #(
  parameter int REG_CNT = 32,
  parameter int XLEN    = 32
);
  localparam int AW = $clog2(REG_CNT);

  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] di3;
  logic            we3;
  logic [AW-1:0]   a4;
  logic [XLEN-1:0] di4;
  logic            we4;
  logic [AW-1:0]   bs_addr;
  logic            bs_en;
  logic            busy1;
  logic            busy2;
  logic            stall;

  modport master (
    output a1, a2, a3, di3, we3, a4, di4, we4, bs_addr, bs_en,
    input  r1, r2, busy1, busy2, stall
  );

  modport slave (
    input  a1, a2, a3, di3, we3, a4, di4, we4, bs_addr, bs_en,
    output r1, r2, busy1, busy2, stall
  );
endinterface

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - two-read, two-write register file with load scoreboard
//
// Purpose: REG_CNT x XLEN general purpose registers with one busy bit per
//          register. Port A (ALU) and port B (load) write on the rising edge;
//          port B also retires the pending load for its address. bs_en marks
//          an address pending when a load is issued. busy1/busy2/stall report
//          pending sources combinationally.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all registers and busy bits
//   bus    scoreboard_regfile_if.slave (see interface file for signal list)
// Parameters:
//   REG_CNT   number of registers (power of two, >= 2)
//   XLEN      register width
//   ZERO_REG  1: register 0 reads zero, ignores writes and busy sets
// Configuration macro:
//   SCOREBOARD_REGFILE_BYPASS_EN  forward same-cycle write data to the read
//                                 ports and same-cycle load retire to busy
module scoreboard_regfile #(
  parameter int REG_CNT  = 32,
  parameter int XLEN     = 32,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                reset,
  scoreboard_regfile_if.slave bus
);
  localparam int AW = $clog2(REG_CNT);
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]    rf_q [REG_CNT];
  logic [XLEN-1:0]    rf_d [REG_CNT];
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_d;

  logic [XLEN:0] rd1;
  logic [XLEN:0] rd2;

  // Next state. Port B is applied first so port A overwrites it on an
  // address collision; the busy clear is applied before the set so a
  // same-cycle set on the same address wins.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (bus.we4) begin
      rf_d[bus.a4]   = bus.di4;
      busy_d[bus.a4] = 1'b0;
    end
    if (bus.we3) begin
      rf_d[bus.a3] = bus.di3;
    end
    if (bus.bs_en) begin
      busy_d[bus.bs_addr] = 1'b1;
    end
    if (ZR) begin
      rf_d[0]   = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        rf_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  // One read port: returns {busy, data} for address a.
  function automatic logic [XLEN:0] rd_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] data;
    logic            busy;
    data = rf_q[a];
    busy = busy_q[a];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    if (bus.we4 && (bus.a4 == a)) begin
      data = bus.di4;
      // A load retiring this cycle is no longer pending, unless a new load
      // to the same register is issued in the same cycle.
      if (!(bus.bs_en && (bus.bs_addr == a))) begin
        busy = 1'b0;
      end
    end
    if (bus.we3 && (bus.a3 == a)) begin
      data = bus.di3;
    end
`endif
    if (ZR && (a == '0)) begin
      data = '0;
      busy = 1'b0;
    end
    // Outputs are held low for the whole reset window, including any
    // forwarded write data.
    if (reset) begin
      data = '0;
      busy = 1'b0;
    end
    return {busy, data};
  endfunction

  always_comb begin
    rd1 = rd_port(bus.a1);
    rd2 = rd_port(bus.a2);
  end

  assign bus.r1    = rd1[XLEN-1:0];
  assign bus.r2    = rd2[XLEN-1:0];
  assign bus.busy1 = rd1[XLEN];
  assign bus.busy2 = rd2[XLEN];
  assign bus.stall = rd1[XLEN] | rd2[XLEN];
endmodule
